// File: rtl/ysyx_23060332_exu_mc_if.sv
// Handshake and memory-port bundle of the ysyx_23060332 multi-cycle execute stage.
// master: the execute stage; slave: the surrounding decode / memory / writeback side.
interface ysyx_23060332_exu_mc_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned STRB = XLEN / 8;

  // decode -> execute
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst_i;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] op1_jump;
  logic [XLEN-1:0] op2_jump;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      waddr_i;
  logic            reg_wen_i;

  // data memory request / response
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [STRB-1:0] mem_wmask;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rdata;

  // execute -> writeback / PC update
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      waddr_o;
  logic [XLEN-1:0] wdata;
  logic            reg_wen_o;
  logic            jump_en;
  logic [XLEN-1:0] jump_addr;

  modport master (
    input  in_valid, inst_i, op1, op2, op1_jump, op2_jump, rs2_data, waddr_i, reg_wen_i,
    input  mem_req_ready, mem_rsp_valid, mem_rdata, out_ready,
    output in_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    output out_valid, waddr_o, wdata, reg_wen_o, jump_en, jump_addr
  );

  modport slave (
    output in_valid, inst_i, op1, op2, op1_jump, op2_jump, rs2_data, waddr_i, reg_wen_i,
    output mem_req_ready, mem_rsp_valid, mem_rdata, out_ready,
    input  in_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  out_valid, waddr_o, wdata, reg_wen_o, jump_en, jump_addr
  );
endinterface

// File: rtl/ysyx_23060332_exu_mc.sv
// Multi-cycle handshaked execute stage: ALU, branches, jumps, loads/stores over a
// request/response memory port, optional shift-add multiplier.
// Optional feature macro: YSYX_23060332_MUL_EN enables the iterative MUL instruction.
module ysyx_23060332_exu_mc #(
  parameter int unsigned XLEN = 32
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_23060332_exu_mc_if.master bus
);

  localparam int unsigned SHW  = $clog2(XLEN);
  localparam int unsigned STRB = XLEN / 8;
  localparam int unsigned OFFW = $clog2(STRB);
`ifdef YSYX_23060332_MUL_EN
  localparam int unsigned CNTW = SHW + 1;
`endif

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

`ifdef YSYX_23060332_MUL_EN
  typedef enum logic [2:0] {S_IDLE, S_MEM_REQ, S_MEM_WAIT, S_MUL, S_DONE} state_t;
  typedef enum logic [2:0] {K_NOP, K_WB, K_BR, K_JMP, K_LD, K_ST, K_MUL} kind_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_MEM_REQ, S_MEM_WAIT, S_DONE} state_t;
  typedef enum logic [2:0] {K_NOP, K_WB, K_BR, K_JMP, K_LD, K_ST} kind_t;
`endif

  state_t state;

  // instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [6:0] funct7_sh;
  logic       unused_inst;

  assign opcode      = bus.inst_i[6:0];
  assign funct3      = bus.inst_i[14:12];
  assign funct7      = bus.inst_i[31:25];
  // RV64 shift immediates borrow bit 25 for shamt[5]
  assign funct7_sh   = (XLEN == 64) ? {bus.inst_i[31:26], 1'b0} : bus.inst_i[31:25];
  assign unused_inst = ^{bus.inst_i[24:15], bus.inst_i[11:7]};

  // integer ALU shared by OP and OP-IMM
  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [SHW-1:0]  sa;
    logic [XLEN-1:0] r;
    sa = b[SHW-1:0];
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << sa;
      3'b010:  r = XLEN'($signed(a) < $signed(b));
      3'b011:  r = XLEN'(a < b);
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? XLEN'($signed(a) >>> sa) : (a >> sa);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // align the returned word to the accessed byte lane and extend it
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw, input logic [2:0] f3,
                                               input logic [OFFW-1:0] off);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] r;
    sh = raw >> {off, 3'b000};
    case (f3)
      3'b000:  r = XLEN'($signed(sh[7:0]));
      3'b001:  r = XLEN'($signed(sh[15:0]));
      3'b010:  r = XLEN'($signed(sh[31:0]));
      3'b100:  r = XLEN'(sh[7:0]);
      3'b101:  r = XLEN'(sh[15:0]);
      default: r = sh;
    endcase
    return r;
  endfunction

  // operand sums, memory lane placement
  logic [XLEN-1:0] sum_op;
  logic [XLEN-1:0] sum_jmp;
  logic [OFFW-1:0] addr_off;
  logic [STRB-1:0] size_mask;

  assign sum_op   = bus.op1 + bus.op2;
  assign sum_jmp  = bus.op1_jump + bus.op2_jump;
  assign addr_off = sum_op[OFFW-1:0];

  // byte strobes for the access size, before lane shifting
  always_comb begin
    size_mask = STRB'(4'hF);
    case (funct3[1:0])
      2'b00:   size_mask = STRB'(4'h1);
      2'b01:   size_mask = STRB'(4'h3);
      default: size_mask = STRB'(4'hF);
    endcase
  end

  // instruction classification, branch condition and write-back result
  kind_t           kind;
  logic            alt;
  logic            upper;
  logic            wen_req;
  logic            br_taken;
  logic            wen_fin;
  logic [XLEN-1:0] alu_res;

  always_comb begin
    kind     = K_NOP;
    alt      = 1'b0;
    upper    = 1'b0;
    wen_req  = 1'b0;
    br_taken = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        kind    = K_WB;
        upper   = 1'b1;
        wen_req = 1'b1;
      end
      OPC_JAL: begin
        kind    = K_JMP;
        wen_req = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          kind    = K_JMP;
          wen_req = 1'b1;
        end
      end
      OPC_BRANCH: begin
        kind = K_BR;
        case (funct3)
          3'b000:  br_taken = (bus.op1 == bus.op2);
          3'b001:  br_taken = (bus.op1 != bus.op2);
          3'b100:  br_taken = ($signed(bus.op1) < $signed(bus.op2));
          3'b101:  br_taken = ($signed(bus.op1) >= $signed(bus.op2));
          3'b110:  br_taken = (bus.op1 < bus.op2);
          3'b111:  br_taken = (bus.op1 >= bus.op2);
          default: kind = K_NOP;
        endcase
      end
      OPC_LOAD: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          kind    = K_LD;
          wen_req = bus.reg_wen_i;
        end
      end
      OPC_STORE: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010}) kind = K_ST;
      end
      OPC_OPIMM: begin
        kind    = K_WB;
        wen_req = bus.reg_wen_i;
        if (funct3 == 3'b001 && funct7_sh != 7'b0000000) kind = K_NOP;
        if (funct3 == 3'b101) begin
          if (funct7_sh == 7'b0100000) alt = 1'b1;
          else if (funct7_sh != 7'b0000000) kind = K_NOP;
        end
      end
      OPC_OP: begin
        wen_req = bus.reg_wen_i;
        if (funct7 == 7'b0000000) begin
          kind = K_WB;
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          kind = K_WB;
          alt  = 1'b1;
`ifdef YSYX_23060332_MUL_EN
        end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          kind = K_MUL;
`endif
        end
      end
      default: kind = K_NOP;
    endcase
    alu_res = upper ? sum_op : alu(funct3, alt, bus.op1, bus.op2);
  end

  // x0 is never written, unsupported ops never write
  assign wen_fin = wen_req && (kind != K_NOP) && (bus.waddr_i != 5'd0);

  assign bus.in_ready = (state == S_IDLE);

  // latched load format for response extraction
  logic [2:0]      ld_f3;
  logic [OFFW-1:0] ld_off;

`ifdef YSYX_23060332_MUL_EN
  logic [XLEN-1:0] mul_mcand;
  logic [XLEN-1:0] mul_mplier;
  logic [XLEN-1:0] mul_acc;
  logic [CNTW-1:0] mul_cnt;
  logic [XLEN-1:0] mul_acc_nxt;

  assign mul_acc_nxt = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`endif

  // control FSM with all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      bus.out_valid     <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
      bus.mem_wmask     <= '0;
      bus.waddr_o       <= '0;
      bus.wdata         <= '0;
      bus.reg_wen_o     <= 1'b0;
      bus.jump_en       <= 1'b0;
      bus.jump_addr     <= '0;
      ld_f3             <= '0;
      ld_off            <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            bus.waddr_o   <= bus.waddr_i;
            bus.reg_wen_o <= wen_fin;
            bus.wdata     <= '0;
            bus.jump_en   <= 1'b0;
            bus.jump_addr <= '0;
            case (kind)
              K_WB: begin
                bus.wdata     <= alu_res;
                bus.out_valid <= 1'b1;
                state         <= S_DONE;
              end
              K_JMP: begin
                bus.wdata     <= sum_op;
                bus.jump_en   <= 1'b1;
                bus.jump_addr <= (opcode == OPC_JALR) ? {sum_jmp[XLEN-1:1], 1'b0} : sum_jmp;
                bus.out_valid <= 1'b1;
                state         <= S_DONE;
              end
              K_BR: begin
                bus.jump_en   <= br_taken;
                bus.jump_addr <= br_taken ? sum_jmp : '0;
                bus.out_valid <= 1'b1;
                state         <= S_DONE;
              end
              K_LD, K_ST: begin
                bus.mem_req_valid <= 1'b1;
                bus.mem_we        <= (kind == K_ST);
                bus.mem_addr      <= sum_op;
                bus.mem_wdata     <= bus.rs2_data << {addr_off, 3'b000};
                bus.mem_wmask     <= size_mask << addr_off;
                ld_f3             <= funct3;
                ld_off            <= addr_off;
                state             <= S_MEM_REQ;
              end
`ifdef YSYX_23060332_MUL_EN
              K_MUL: begin
                mul_mcand  <= bus.op1;
                mul_mplier <= bus.op2;
                mul_acc    <= '0;
                mul_cnt    <= '0;
                state      <= S_MUL;
              end
`endif
              default: begin
                bus.out_valid <= 1'b1;
                state         <= S_DONE;
              end
            endcase
          end
        end
        S_MEM_REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            if (bus.mem_we) begin
              bus.out_valid <= 1'b1;
              state         <= S_DONE;
            end else begin
              state <= S_MEM_WAIT;
            end
          end
        end
        S_MEM_WAIT: begin
          if (bus.mem_rsp_valid) begin
            bus.wdata     <= load_ext(bus.mem_rdata, ld_f3, ld_off);
            bus.out_valid <= 1'b1;
            state         <= S_DONE;
          end
        end
`ifdef YSYX_23060332_MUL_EN
        S_MUL: begin
          mul_acc    <= mul_acc_nxt;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + CNTW'(1);
          if (mul_cnt == CNTW'(XLEN - 1)) begin
            bus.wdata     <= mul_acc_nxt;
            bus.out_valid <= 1'b1;
            state         <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
